// File: rtl/controller_if.sv
// Instruction/control bundle between the decode stage and the datapath controller.
// The controller takes the slave view: it samples opcode/cond and drives every control strobe.
interface controller_if;
  logic [6:0] opcode;
  logic [3:0] cond;
  logic       waiting;
  logic [1:0] wb_sel;
  logic       sel_A, sel_B, sel_shift;
  logic       w_en, en_A, en_B, en_C, en_S;
  logic [2:0] ALU_op;
  logic       load_ir, load_pc, clear_pc;
  logic       load_addr, sel_addr, ram_w_en;

  modport master (
    output opcode, cond,
    input  waiting, wb_sel, sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_S,
           ALU_op, load_ir, load_pc, clear_pc, load_addr, sel_addr, ram_w_en
  );

  modport slave (
    input  opcode, cond,
    output waiting, wb_sel, sel_A, sel_B, sel_shift, w_en, en_A, en_B, en_C, en_S,
           ALU_op, load_ir, load_pc, clear_pc, load_addr, sel_addr, ram_w_en
  );
endinterface

// File: rtl/controller.sv
// Multi-cycle Moore control FSM: START -> FETCH -> EXECUTE -> [MEM] -> [WRITEBACK].
// All strobes decode from the state and the opcode/cond captured when FETCH exits.
module controller (
  input  logic        clk,
  input  logic        rst_n,
  controller_if.slave bus
);

  typedef enum logic [2:0] {START, FETCH, EXECUTE, MEM, WRITEBACK} state_t;

  typedef struct packed {
    logic       sel_a;
    logic       sel_b;
    logic       sel_shift;
    logic [2:0] alu_op;
    logic       is_ldr;
    logic       is_str;
    logic       is_cmp;
    logic       is_nop;
  } dec_t;

  state_t     state, state_nx;
  logic [6:0] op_q;
  logic [3:0] cond_q;
  dec_t       dec;
  logic       never;
  logic       exec_done;

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= START;
      op_q   <= '0;
      cond_q <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH) begin
        op_q   <= bus.opcode;
        cond_q <= bus.cond;
      end
    end
  end

  always_comb begin
    dec = '0;
    unique case (op_q)
      7'b0001000: begin dec.sel_a = 1'b1; end
      7'b0001001: begin dec.sel_a = 1'b1; dec.sel_shift = 1'b1; end
      7'b0011000: begin dec.sel_a = 1'b1; dec.sel_b = 1'b1; end
      7'b1000000: ;
      7'b1000001: begin dec.sel_shift = 1'b1; end
      7'b1010000: begin dec.sel_b = 1'b1; end
      7'b0100000: begin dec.alu_op = 3'b001; end
      7'b0100001: begin dec.sel_shift = 1'b1; dec.alu_op = 3'b001; end
      7'b0110000: begin dec.sel_b = 1'b1; dec.alu_op = 3'b001; end
      7'b1100000: begin dec.alu_op = 3'b001; dec.is_cmp = 1'b1; end
      7'b1110000: begin dec.sel_b = 1'b1; dec.is_ldr = 1'b1; end
      7'b1111000: begin dec.sel_b = 1'b1; dec.is_str = 1'b1; end
      default:    begin dec.is_nop = 1'b1; end
    endcase
  end

  // Suppressed, compare and no-op instructions retire straight out of EXECUTE.
  assign never     = (cond_q == 4'b1111);
  assign exec_done = never | dec.is_cmp | dec.is_nop;

  always_comb begin
    state_nx = state;
    case (state)
      START:     state_nx = FETCH;
      FETCH:     state_nx = EXECUTE;
      EXECUTE: begin
        if (exec_done)                     state_nx = FETCH;
        else if (dec.is_ldr | dec.is_str) state_nx = MEM;
        else                               state_nx = WRITEBACK;
      end
      MEM:       state_nx = dec.is_str ? FETCH : WRITEBACK;
      WRITEBACK: state_nx = FETCH;
      default:   state_nx = START;
    endcase
  end

  always_comb begin
    bus.waiting   = 1'b0;
    bus.wb_sel    = 2'b00;
    bus.sel_A     = 1'b0;
    bus.sel_B     = 1'b0;
    bus.sel_shift = 1'b0;
    bus.w_en      = 1'b0;
    bus.en_A      = 1'b0;
    bus.en_B      = 1'b0;
    bus.en_C      = 1'b0;
    bus.en_S      = 1'b0;
    bus.ALU_op    = 3'b000;
    bus.load_ir   = 1'b0;
    bus.load_pc   = 1'b0;
    bus.clear_pc  = 1'b0;
    bus.load_addr = 1'b0;
    bus.sel_addr  = 1'b0;
    bus.ram_w_en  = 1'b0;
    case (state)
      START: begin
        bus.clear_pc = 1'b1;
        bus.waiting  = 1'b1;
      end
      FETCH: begin
        bus.load_ir = 1'b1;
        bus.waiting = 1'b1;
      end
      EXECUTE: begin
        bus.en_A      = 1'b1;
        bus.en_B      = 1'b1;
        bus.en_C      = 1'b1;
        bus.sel_A     = dec.sel_a;
        bus.sel_B     = dec.sel_b;
        bus.sel_shift = dec.sel_shift;
        bus.ALU_op    = dec.alu_op;
        bus.en_S      = dec.is_cmp & ~never;
        bus.load_pc   = exec_done;
      end
      MEM: begin
        bus.load_addr = 1'b1;
        bus.sel_addr  = 1'b1;
        bus.ram_w_en  = dec.is_str;
        bus.load_pc   = dec.is_str;
      end
      WRITEBACK: begin
        bus.w_en     = 1'b1;
        bus.load_pc  = 1'b1;
        bus.wb_sel   = dec.is_ldr ? 2'b01 : 2'b00;
        bus.sel_addr = dec.is_ldr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed and random instructions against a per-instruction
// cycle-sequence model, plus asynchronous reset mid-instruction.
module tb_controller;

  typedef struct packed {
    logic       waiting;
    logic [1:0] wb_sel;
    logic       sel_a, sel_b, sel_shift;
    logic       w_en, en_a, en_b, en_c, en_s;
    logic [2:0] alu_op;
    logic       load_ir, load_pc, clear_pc, load_addr, sel_addr, ram_w_en;
  } ov_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ov_t  exp_q[$];
  ov_t  start_v, fetch_v;

  controller_if bus();
  controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic ov_t observe();
    ov_t o;
    o.waiting   = bus.waiting;
    o.wb_sel    = bus.wb_sel;
    o.sel_a     = bus.sel_A;
    o.sel_b     = bus.sel_B;
    o.sel_shift = bus.sel_shift;
    o.w_en      = bus.w_en;
    o.en_a      = bus.en_A;
    o.en_b      = bus.en_B;
    o.en_c      = bus.en_C;
    o.en_s      = bus.en_S;
    o.alu_op    = bus.ALU_op;
    o.load_ir   = bus.load_ir;
    o.load_pc   = bus.load_pc;
    o.clear_pc  = bus.clear_pc;
    o.load_addr = bus.load_addr;
    o.sel_addr  = bus.sel_addr;
    o.ram_w_en  = bus.ram_w_en;
    return o;
  endfunction

  task automatic check(input string tag, input ov_t exp);
    ov_t obs;
    obs = observe();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: what each instruction class does, cycle by cycle, starting in EXECUTE.
  task automatic build(input logic [6:0] op, input logic [3:0] c);
    ov_t e, m, w;
    logic sa, sb, ss, sub, ldr, str, cmp, nop, skip;
    {sa, sb, ss, sub, ldr, str, cmp, nop} = '0;
    case (op)
      7'b0001000: sa = 1;
      7'b0001001: begin sa = 1; ss = 1; end
      7'b0011000: begin sa = 1; sb = 1; end
      7'b1000000: ;
      7'b1000001: ss = 1;
      7'b1010000: sb = 1;
      7'b0100000: sub = 1;
      7'b0100001: begin ss = 1; sub = 1; end
      7'b0110000: begin sb = 1; sub = 1; end
      7'b1100000: begin sub = 1; cmp = 1; end
      7'b1110000: begin sb = 1; ldr = 1; end
      7'b1111000: begin sb = 1; str = 1; end
      default:    nop = 1;
    endcase
    skip = (c == 4'hF) || cmp || nop;
    exp_q.delete();
    e = '0;
    e.en_a = 1; e.en_b = 1; e.en_c = 1;
    e.sel_a = sa; e.sel_b = sb; e.sel_shift = ss;
    e.alu_op = sub ? 3'd1 : 3'd0;
    e.en_s = cmp && (c != 4'hF);
    e.load_pc = skip;
    exp_q.push_back(e);
    if (skip) return;
    if (ldr || str) begin
      m = '0;
      m.load_addr = 1; m.sel_addr = 1;
      m.ram_w_en = str; m.load_pc = str;
      exp_q.push_back(m);
      if (str) return;
    end
    w = '0;
    w.w_en = 1; w.load_pc = 1;
    w.wb_sel = ldr ? 2'b01 : 2'b00;
    w.sel_addr = ldr;
    exp_q.push_back(w);
  endtask

  // Called with the DUT in FETCH (checked); leaves it in FETCH again.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [3:0] c);
    logic hit;
    hit = 1'b0;
    bus.opcode = op;
    bus.cond   = c;
    build(op, c);
    @(posedge clk); #1;
    // inputs changing after capture must not disturb the instruction in flight
    bus.opcode = 7'($urandom);
    bus.cond   = 4'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      check($sformatf("%s_step%0d", tag, i), exp_q[i]);
      hit = hit | bus.w_en | bus.ram_w_en | bus.en_S;
    end
    if (c == 4'hF) check_bit({tag, "_suppressed"}, hit, 1'b0);
    @(posedge clk); #1;
    check({tag, "_refetch"}, fetch_v);
  endtask

  logic [6:0] ops [12] = '{7'b0001000, 7'b0001001, 7'b0011000, 7'b1000000,
                           7'b1000001, 7'b1010000, 7'b0100000, 7'b0100001,
                           7'b0110000, 7'b1100000, 7'b1110000, 7'b1111000};

  initial begin
    logic [6:0] rop;
    logic [3:0] rc;
    start_v = '0; start_v.waiting = 1; start_v.clear_pc = 1;
    fetch_v = '0; fetch_v.waiting = 1; fetch_v.load_ir = 1;
    bus.opcode = '0;
    bus.cond   = '0;
    rst_n = 1'b1;
    #1;
    check("reset_async", start_v);
    repeat (2) @(posedge clk);
    #1 check("reset_held", start_v);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("first_fetch", fetch_v);

    run_instr("mov_i",   7'b0011000, 4'h0);
    run_instr("mov_r",   7'b0001000, 4'h0);
    run_instr("sub_rs",  7'b0100001, 4'h0);
    run_instr("ldr",     7'b1110000, 4'h0);
    run_instr("str",     7'b1111000, 4'h3);
    run_instr("cmp",     7'b1100000, 4'h0);
    run_instr("nop",     7'b0000000, 4'h0);
    run_instr("add_nv",  7'b1010000, 4'hF);
    run_instr("ldr_nv",  7'b1110000, 4'hF);
    run_instr("str_nv",  7'b1111000, 4'hF);
    run_instr("cmp_nv",  7'b1100000, 4'hF);
    run_instr("add_rs",  7'b1000001, 4'hE);

    for (int k = 0; k < 60; k++) begin
      rop = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       rc = 4'h0;
        1:       rc = 4'hF;
        default: rc = 4'($urandom);
      endcase
      run_instr($sformatf("rnd%0d", k), rop, rc);
    end

    // reset in WRITEBACK drops w_en before the next edge
    bus.opcode = 7'b1010000; bus.cond = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_bit("wb_before_reset", bus.w_en, 1'b1);
    #2 rst_n = 1'b1;
    #1 check("reset_in_wb", start_v);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("fetch_after_wb_reset", fetch_v);

    // reset in MEM of a store kills ram_w_en
    bus.opcode = 7'b1111000; bus.cond = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_bit("mem_before_reset", bus.ram_w_en, 1'b1);
    #1 rst_n = 1'b1;
    #1 check("reset_in_mem", start_v);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("fetch_after_mem_reset", fetch_v);
    run_instr("post_reset_ldr", 7'b1110000, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
